ex: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline; sits directly downstream of ID and upstream of MEM.
- Registers the ID→EX bus and evaluates the one-hot ALU.
- Issues the data-SRAM request and drives the EX forwarding bus back to ID.
- Owns HI/LO and a 32-iteration divider for div/divu, stalling the pipeline while it runs.

---
 rtl/ex_pkg.sv | 59 +++++
 rtl/ex_div_iter.sv | 104 ++++++++++
 rtl/ex.sv | 143 ++++++++++++++
 tb/tb_ex.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared widths, stall encoding, divider state type and the ID->EX bus layout
// for the execute stage.
package ex_pkg;

    localparam int ID_TO_EX_WD  = 159;
    localparam int EX_TO_MEM_WD = 76;
    localparam int EX_TO_RF_WD  = 38;
    localparam int STALL_WD     = 6;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    // Bit positions inside the one-hot alu_op field
    localparam int ALU_ADD  = 11;
    localparam int ALU_SUB  = 10;
    localparam int ALU_SLT  = 9;
    localparam int ALU_SLTU = 8;
    localparam int ALU_AND  = 7;
    localparam int ALU_NOR  = 6;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 3;
    localparam int ALU_SRL  = 2;
    localparam int ALU_SRA  = 1;
    localparam int ALU_LUI  = 0;

    localparam logic [5:0] FN_DIV  = 6'h1A;
    localparam logic [5:0] FN_DIVU = 6'h1B;
    localparam logic [5:0] FN_MFHI = 6'h10;
    localparam logic [5:0] FN_MFLO = 6'h12;
    localparam logic [5:0] FN_MTHI = 6'h11;
    localparam logic [5:0] FN_MTLO = 6'h13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  src1;
        logic [3:0]  src2;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sel_rf_res;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
    } id_ex_t;

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/ex_div_iter.sv
// 32-iteration restoring divider with signed fixup; holds its result in DONE
// until the pipeline acknowledges it.
module div_iter
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        ack_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o,
    output logic        busy_o,
    output logic        done_o
);

    div_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic        dvz_q, dvz_d;
    logic [32:0] shifted;
    logic [32:0] diff;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dvz_d   = dvz_q;
        shifted = {rem_q, quo_q[31]};
        diff    = shifted - {1'b0, dvs_q};
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = mag32(dividend_i, signed_i);
                    dvs_d   = mag32(divisor_i, signed_i);
                    negq_d  = signed_i && (dividend_i[31] ^ divisor_i[31]);
                    negr_d  = signed_i && dividend_i[31];
                    dvz_d   = (divisor_i == '0);
                end
            end
            BUSY: begin
                if (!start_i) begin
                    state_d = IDLE;
                end else begin
                    // A clear borrow bit means the trial subtraction fits.
                    if (!diff[32]) begin
                        rem_d = diff[31:0];
                        quo_d = {quo_q[30:0], 1'b1};
                    end else begin
                        rem_d = shifted[31:0];
                        quo_d = {quo_q[30:0], 1'b0};
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_d = DONE;
                end
            end
            DONE: begin
                if (!start_i || ack_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dvz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dvz_q   <= dvz_d;
        end
    end

    assign busy_o      = start_i && (state_q != DONE);
    assign done_o      = start_i && (state_q == DONE);
    assign quotient_o  = dvz_q ? '1 : (negq_q ? (~quo_q + 32'd1) : quo_q);
    assign remainder_o = negr_q ? (~rem_q + 32'd1) : rem_q;

endmodule

// File: rtl/ex.sv
// Execute stage: ID->EX register, one-hot ALU, data-SRAM request, forwarding
// bus, HI/LO and the iterative divider for div/divu.
module ex
    import ex_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    output logic                    stallreq_for_ex,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata
);

    id_ex_t id_q, id_d;

    always_comb begin
        id_d = id_q;
        if (stall[2] == STOP && stall[3] == NOSTOP) begin
            id_d = '0;
        end else if (stall[2] == NOSTOP) begin
            id_d = id_ex_t'(id_to_ex_bus);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) id_q <= '0;
        else     id_q <= id_d;
    end

    logic       is_special;
    logic [5:0] func;
    logic       is_div, is_divu, is_mfhi, is_mflo, is_mthi, is_mtlo, is_mf;

    assign is_special = (id_q.inst[31:26] == 6'd0);
    assign func       = id_q.inst[5:0];
    assign is_div     = is_special && (func == FN_DIV);
    assign is_divu    = is_special && (func == FN_DIVU);
    assign is_mfhi    = is_special && (func == FN_MFHI);
    assign is_mflo    = is_special && (func == FN_MFLO);
    assign is_mthi    = is_special && (func == FN_MTHI);
    assign is_mtlo    = is_special && (func == FN_MTLO);
    assign is_mf      = is_mfhi || is_mflo;

    logic [31:0] op1, op2, alu_res;
    logic [4:0]  sa;

    assign op1 = ({32{id_q.src1[0]}} & id_q.rdata1)
               | ({32{id_q.src1[1]}} & id_q.pc)
               | ({32{id_q.src1[2]}} & {27'b0, id_q.inst[10:6]});
    assign op2 = ({32{id_q.src2[0]}} & id_q.rdata2)
               | ({32{id_q.src2[1]}} & {{16{id_q.inst[15]}}, id_q.inst[15:0]})
               | ({32{id_q.src2[2]}} & 32'd8)
               | ({32{id_q.src2[3]}} & {16'b0, id_q.inst[15:0]});
    assign sa  = op1[4:0];

    always_comb begin
        alu_res = '0;
        if (id_q.alu_op[ALU_ADD])  alu_res = alu_res | (op1 + op2);
        if (id_q.alu_op[ALU_SUB])  alu_res = alu_res | (op1 - op2);
        if (id_q.alu_op[ALU_SLT])  alu_res = alu_res | {31'b0, $signed(op1) < $signed(op2)};
        if (id_q.alu_op[ALU_SLTU]) alu_res = alu_res | {31'b0, op1 < op2};
        if (id_q.alu_op[ALU_AND])  alu_res = alu_res | (op1 & op2);
        if (id_q.alu_op[ALU_NOR])  alu_res = alu_res | ~(op1 | op2);
        if (id_q.alu_op[ALU_OR])   alu_res = alu_res | (op1 | op2);
        if (id_q.alu_op[ALU_XOR])  alu_res = alu_res | (op1 ^ op2);
        if (id_q.alu_op[ALU_SLL])  alu_res = alu_res | (op2 << sa);
        if (id_q.alu_op[ALU_SRL])  alu_res = alu_res | (op2 >> sa);
        if (id_q.alu_op[ALU_SRA])  alu_res = alu_res | 32'($signed(op2) >>> sa);
        if (id_q.alu_op[ALU_LUI])  alu_res = alu_res | {op2[15:0], 16'b0};
    end

    logic [31:0] div_quo, div_rem;
    logic        div_done;

    div_iter u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (is_div || is_divu),
        .ack_i      (stall[3] == NOSTOP),
        .signed_i   (is_div),
        .dividend_i (id_q.rdata1),
        .divisor_i  (id_q.rdata2),
        .quotient_o (div_quo),
        .remainder_o(div_rem),
        .busy_o     (stallreq_for_ex),
        .done_o     (div_done)
    );

    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    // HI/LO commit only as the instruction leaves EX, so a following mfhi/mflo
    // sees the new value without forwarding.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (stall[3] == NOSTOP) begin
            if (div_done) begin
                hi_d = div_rem;
                lo_d = div_quo;
            end else if (is_mthi) begin
                hi_d = id_q.rdata1;
            end else if (is_mtlo) begin
                lo_d = id_q.rdata1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;

    assign rf_we     = is_mf || id_q.rf_we;
    assign rf_waddr  = is_mf ? id_q.inst[15:11] : id_q.rf_waddr;
    assign ex_result = is_mfhi ? hi_q : (is_mflo ? lo_q : alu_res);

    assign ex_to_mem_bus = {id_q.pc, id_q.ram_en, id_q.ram_wen, id_q.sel_rf_res,
                            rf_we, rf_waddr, ex_result};
    assign ex_to_rf_bus  = {rf_we, rf_waddr, ex_result};

    assign data_sram_en    = id_q.ram_en;
    assign data_sram_wen   = id_q.ram_wen;
    assign data_sram_addr  = alu_res;
    assign data_sram_wdata = id_q.rdata2;

    logic unused_bits;
    assign unused_bits = ^{stall[5:4], stall[1:0], id_q.inst[25:16]};

endmodule

// File: tb/tb_ex.sv
// Self-checking bench for the execute stage: directed cases plus random ALU
// operations and divisions against an arithmetic reference model.
module tb_ex;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall_drv;
    logic [5:0]   stall;
    logic         stallreq_for_ex;
    logic [158:0] id_to_ex_bus;
    logic [75:0]  ex_to_mem_bus;
    logic [37:0]  ex_to_rf_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Pipeline control reaction: a divider stall request freezes IF..EX.
    assign stall = stall_drv | (stallreq_for_ex ? 6'b001111 : 6'b000000);

    ex dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .stallreq_for_ex(stallreq_for_ex),
        .id_to_ex_bus   (id_to_ex_bus),
        .ex_to_mem_bus  (ex_to_mem_bus),
        .ex_to_rf_bus   (ex_to_rf_bus),
        .data_sram_en   (data_sram_en),
        .data_sram_wen  (data_sram_wen),
        .data_sram_addr (data_sram_addr),
        .data_sram_wdata(data_sram_wdata)
    );

    task automatic check(input string tag, input logic [75:0] obs, input logic [75:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                        input logic [11:0] op, input logic [2:0] s1,
                                        input logic [3:0] s2, input logic ren,
                                        input logic [3:0] wen, input logic we,
                                        input logic [4:0] wa, input logic sel,
                                        input logic [31:0] r1, input logic [31:0] r2);
        return {pc, inst, op, s1, s2, ren, wen, we, wa, sel, r1, r2};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, 5'd0, 5'd0, rd, 5'd0, fn};
    endfunction

    // Reference ALU: op index 0..11 = add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui
    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        int     sh;
        sa = $signed(a);
        sb = $signed(b);
        sh = int'(a % 32);
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return (sa < sb) ? 32'd1 : 32'd0;
            3:  return (a < b) ? 32'd1 : 32'd0;
            4:  return a & b;
            5:  return ~(a | b);
            6:  return a | b;
            7:  return a ^ b;
            8:  return b * (32'd1 << sh);
            9:  return b / (32'd1 << sh);
            10: begin
                sb = sb >>> sh;
                return sb[31:0];
            end
            default: return b * 32'd65536;
        endcase
    endfunction

    // Reference divide: returns {hi, lo}
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run_div(input string tag, input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int n;
        exp = ref_div(sgn, a, b);
        id_to_ex_bus = mk(32'h1000, rtype(5'd0, sgn ? 6'h1A : 6'h1B), 12'h000, 3'b000,
                          4'b0000, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, a, b);
        tick();
        id_to_ex_bus = mk(32'h1004, rtype(5'd8, 6'h12), 12'h000, 3'b000, 4'b0000,
                          1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
        n = 0;
        while (stallreq_for_ex === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check({tag, "_stall_cycles"}, 76'(n), 76'(33));
        check({tag, "_no_rf_we"}, 76'(ex_to_rf_bus[37]), 76'(0));
        tick();
        check({tag, "_lo"}, 76'(ex_to_rf_bus), 76'({1'b1, 5'd8, exp[31:0]}));
        id_to_ex_bus = mk(32'h1008, rtype(5'd9, 6'h10), 12'h000, 3'b000, 4'b0000,
                          1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
        tick();
        check({tag, "_hi"}, 76'(ex_to_rf_bus), 76'({1'b1, 5'd9, exp[63:32]}));
    endtask

    initial begin
        logic [158:0] addiu_b, sw_b;
        rst          = 1'b1;
        stall_drv    = 6'b0;
        id_to_ex_bus = '0;
        tick();
        tick();
        check("rst_mem_bus", ex_to_mem_bus, 76'(0));
        check("rst_rf_bus", 76'(ex_to_rf_bus), 76'(0));
        check("rst_stallreq", 76'(stallreq_for_ex), 76'(0));
        check("rst_sram_en", 76'(data_sram_en), 76'(0));
        rst = 1'b0;

        addiu_b = mk(32'hBFC0_0000, {6'h09, 5'd1, 5'd2, 16'hFFFF}, 12'h800, 3'b001, 4'b0010,
                     1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'd5, 32'd0);
        id_to_ex_bus = addiu_b;
        tick();
        check("addiu_rf", 76'(ex_to_rf_bus), 76'({1'b1, 5'd2, 32'd4}));

        id_to_ex_bus = mk(32'h4, {6'h00, 5'd0, 5'd3, 5'd4, 5'd4, 6'h00}, 12'h008, 3'b100, 4'b0001,
                          1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'd0, 32'd1);
        tick();
        check("sll", 76'(ex_to_rf_bus[31:0]), 76'(32'h10));

        id_to_ex_bus = mk(32'h8, {6'h0F, 5'd0, 5'd5, 16'h1234}, 12'h001, 3'b001, 4'b1000,
                          1'b0, 4'h0, 1'b1, 5'd5, 1'b0, 32'd0, 32'd0);
        tick();
        check("lui", 76'(ex_to_rf_bus[31:0]), 76'(32'h1234_0000));

        id_to_ex_bus = mk(32'hC, 32'h0000_002A, 12'h200, 3'b001, 4'b0001,
                          1'b0, 4'h0, 1'b1, 5'd6, 1'b0, 32'hFFFF_FFFF, 32'd1);
        tick();
        check("slt", 76'(ex_to_rf_bus[31:0]), 76'(1));
        id_to_ex_bus = mk(32'h10, 32'h0000_002B, 12'h100, 3'b001, 4'b0001,
                          1'b0, 4'h0, 1'b1, 5'd6, 1'b0, 32'hFFFF_FFFF, 32'd1);
        tick();
        check("sltu", 76'(ex_to_rf_bus[31:0]), 76'(0));

        sw_b = mk(32'hBFC0_0010, {6'h2B, 5'd1, 5'd2, 16'h0008}, 12'h800, 3'b001, 4'b0010,
                  1'b1, 4'hF, 1'b0, 5'd0, 1'b0, 32'h100, 32'hDEAD_BEEF);
        id_to_ex_bus = sw_b;
        tick();
        check("sw_en", 76'(data_sram_en), 76'(1));
        check("sw_wen", 76'(data_sram_wen), 76'(4'hF));
        check("sw_addr", 76'(data_sram_addr), 76'(32'h108));
        check("sw_wdata", 76'(data_sram_wdata), 76'(32'hDEAD_BEEF));
        check("sw_mem_bus", ex_to_mem_bus,
              {32'hBFC0_0010, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h108});

        id_to_ex_bus = addiu_b;
        stall_drv    = 6'b000100;
        tick();
        check("bubble_mem_bus", ex_to_mem_bus, 76'(0));
        check("bubble_sram_en", 76'(data_sram_en), 76'(0));
        stall_drv    = 6'b0;
        id_to_ex_bus = sw_b;
        tick();
        id_to_ex_bus = addiu_b;
        stall_drv    = 6'b001100;
        tick();
        check("hold_addr", 76'(data_sram_addr), 76'(32'h108));
        check("hold_mem_bus", ex_to_mem_bus,
              {32'hBFC0_0010, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h108});
        stall_drv = 6'b0;

        id_to_ex_bus = mk(32'h20, {6'h00, 5'd1, 15'd0, 6'h11}, 12'h000, 3'b000, 4'b0000,
                          1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'h1357_9BDF, 32'd0);
        tick();
        id_to_ex_bus = mk(32'h24, {6'h00, 5'd1, 15'd0, 6'h13}, 12'h000, 3'b000, 4'b0000,
                          1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'h2468_ACE0, 32'd0);
        tick();
        id_to_ex_bus = mk(32'h28, rtype(5'd7, 6'h10), 12'h000, 3'b000, 4'b0000,
                          1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
        tick();
        check("mthi_mfhi", 76'(ex_to_rf_bus), 76'({1'b1, 5'd7, 32'h1357_9BDF}));
        id_to_ex_bus = mk(32'h2C, rtype(5'd7, 6'h12), 12'h000, 3'b000, 4'b0000,
                          1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
        tick();
        check("mtlo_mflo", 76'(ex_to_rf_bus), 76'({1'b1, 5'd7, 32'h2468_ACE0}));

        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_div("divu_7_0", 1'b0, 32'd7, 32'd0);
        run_div("div_m7_0", 1'b1, 32'hFFFF_FFF9, 32'd0);
        run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);

        // Reset in the middle of a division
        id_to_ex_bus = mk(32'h40, rtype(5'd0, 6'h1B), 12'h000, 3'b000, 4'b0000,
                          1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'd1000, 32'd7);
        tick();
        id_to_ex_bus = '0;
        for (int i = 0; i < 10; i++) tick();
        check("busy_before_rst", 76'(stallreq_for_ex), 76'(1));
        rst = 1'b1;
        tick();
        check("rst_mid_stallreq", 76'(stallreq_for_ex), 76'(0));
        rst = 1'b0;
        id_to_ex_bus = mk(32'h44, rtype(5'd3, 6'h10), 12'h000, 3'b000, 4'b0000,
                          1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
        tick();
        check("rst_mid_hi", 76'(ex_to_rf_bus), 76'({1'b1, 5'd3, 32'd0}));
        id_to_ex_bus = mk(32'h48, rtype(5'd3, 6'h12), 12'h000, 3'b000, 4'b0000,
                          1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
        tick();
        check("rst_mid_lo", 76'(ex_to_rf_bus), 76'({1'b1, 5'd3, 32'd0}));

        for (int k = 0; k < 30; k++) begin
            int          op, s1, s2;
            logic [31:0] pc, inst, r1, r2, a, b, exp;
            logic [4:0]  wa;
            op   = int'($urandom_range(0, 11));
            s1   = int'($urandom_range(0, 2));
            s2   = int'($urandom_range(0, 3));
            pc   = $urandom;
            inst = {6'h08, 26'($urandom)};
            r1   = $urandom;
            r2   = $urandom;
            wa   = 5'($urandom);
            a = (s1 == 0) ? r1 : (s1 == 1) ? pc : {27'd0, inst[10:6]};
            case (s2)
                0:       b = r2;
                1:       b = 32'($signed(inst[15:0]));
                2:       b = 32'd8;
                default: b = {16'd0, inst[15:0]};
            endcase
            exp = ref_alu(op, a, b);
            id_to_ex_bus = mk(pc, inst, 12'h800 >> op, 3'b001 << s1, 4'b0001 << s2,
                              1'b0, 4'h0, 1'b1, wa, 1'b0, r1, r2);
            tick();
            check($sformatf("rand_alu%0d_op%0d_rf", k, op), 76'(ex_to_rf_bus), 76'({1'b1, wa, exp}));
            check($sformatf("rand_alu%0d_op%0d_addr", k, op), 76'(data_sram_addr), 76'(exp));
        end

        for (int k = 0; k < 6; k++) begin
            logic [31:0] a, b;
            bit          sgn;
            sgn = 1'($urandom);
            a   = $urandom;
            b   = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 9)) : 32'($urandom >> $urandom_range(0, 28));
            if ($urandom_range(0, 1) == 1) b = ~b + 32'd1;
            run_div($sformatf("rand_div%0d", k), sgn, a, b);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
